// File: rtl/exe_stage_mdu.sv
// Iterative RV64M multiply/divide unit: 1-bit/cycle shift-add multiplier and
// restoring divider behind valid/ready handshakes, W-forms sign-extended from bit 31.
module exe_stage_mdu #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      mdu_op,
   input  logic            is_word_opt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] mdu_output,
   output logic            busy
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic                word_q;
   logic [XLEN-1:0]     a_q, b_q;
   logic [XLEN-1:0]     addend_q;
   logic                neg_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*XLEN-1:0]   acc_q;

   function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] v, input logic w);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Operand conditioning, evaluated from the latched request
   logic            is_mulh, is_div, is_rem, sign_a, sign_b, word_eff;
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val, special_res;
   logic            sa, sb, div_zero, div_ovf, special, accept;

   assign is_mulh  = ~op_q[2] & (op_q[1:0] != 2'b00);
   assign is_div   = op_q[2];
   assign is_rem   = op_q[2] & op_q[1];
   assign sign_a   = (op_q == OP_MUL) | (op_q == OP_MULH) | (op_q == OP_MULHSU) |
                     (op_q == OP_DIV) | (op_q == OP_REM);
   assign sign_b   = (op_q == OP_MUL) | (op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM);
   assign word_eff = word_q & ~is_mulh;
   assign ext_a    = word_eff ? {{(XLEN-32){sign_a & a_q[31]}}, a_q[31:0]} : a_q;
   assign ext_b    = word_eff ? {{(XLEN-32){sign_b & b_q[31]}}, b_q[31:0]} : b_q;
   assign sa       = sign_a & ext_a[XLEN-1];
   assign sb       = sign_b & ext_b[XLEN-1];
   assign mag_a    = sa ? -ext_a : ext_a;
   assign mag_b    = sb ? -ext_b : ext_b;
   assign min_val  = word_eff ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
   assign div_zero = (ext_b == '0);
   assign div_ovf  = sign_b & (ext_a == min_val) & (ext_b == '1);
   assign special  = is_div & (div_zero | div_ovf);
   assign special_res = fmt_w(is_rem ? (div_zero ? ext_a : '0) : (div_zero ? '1 : ext_a), word_eff);

   // One iteration of multiply (add-then-shift-right) or restoring divide
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] acc_step;

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, addend_q} : '0);
   assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, addend_q});
   assign div_diff  = div_shift[XLEN-1:0] - addend_q;
   assign acc_step  = is_div ? {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                             : {mul_sum, acc_q[XLEN-1:1]};

   // Result selection and sign fixup; word products sit 32 bits higher in the accumulator
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, fix_res;

   assign prod    = word_eff ? {32'b0, acc_q[2*XLEN-1:32]} : acc_q;
   assign prod_s  = neg_q ? -prod : prod;
   assign quo_s   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_s   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign fix_res = fmt_w(is_rem ? rem_s : is_div ? quo_s :
                          is_mulh ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0], word_eff);

   assign in_ready  = rst & (state_q == S_IDLE) & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = S_PREP;
         S_PREP:  state_d = special ? S_DONE : S_CALC;
         S_CALC:  if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
         S_FIXUP: state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= '0;
         word_q     <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         addend_q   <= '0;
         neg_q      <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         mdu_output <= '0;
      end else begin
         if (accept) begin
            op_q   <= mdu_op;
            word_q <= is_word_opt;
            a_q    <= op1;
            b_q    <= op2;
         end
         unique case (state_q)
            S_PREP: if (!flush) begin
               addend_q <= is_div ? mag_b : mag_a;
               neg_q    <= is_rem ? sa : (sa ^ sb);
               cnt_q    <= word_eff ? CNT_W'(32) : CNT_W'(XLEN);
               acc_q    <= is_div ? {{XLEN{1'b0}}, (word_eff ? {mag_a[31:0], 32'b0} : mag_a)}
                                  : {{XLEN{1'b0}}, mag_b};
               if (special) mdu_output <= special_res;
            end
            S_CALC: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - CNT_W'(1);
            end
            S_FIXUP: if (!flush) mdu_output <= fix_res;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed self-checking bench for exe_stage_mdu: arithmetic results, latencies,
// special cases, output stall, flush and asynchronous reset.
module tb_exe_stage_mdu;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] op1 = '0;
   logic [63:0] op2 = '0;
   logic [2:0]  mdu_op = '0;
   logic        is_word_opt = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] mdu_output;
   logic        busy;

   int tests_run = 0;
   int tests_failed = 0;

   exe_stage_mdu #(.XLEN(64), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .mdu_op(mdu_op), .is_word_opt(is_word_opt),
      .out_valid(out_valid), .out_ready(out_ready), .mdu_output(mdu_output), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic w);
      @(negedge clk);
      in_valid = 1'b1; mdu_op = op; op1 = a; op2 = b; is_word_opt = w;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Returns the cycle (accept = 0) at which out_valid is first seen, or -1 on timeout
   task automatic wait_valid(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 200 && cyc < 0; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) cyc = i;
      end
   endtask

   task automatic handoff;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic w, output int lat, output logic [63:0] res);
      start_op(op, a, b, w);
      wait_valid(lat);
      res = mdu_output;
      if (lat >= 0) handoff();
   endtask

   task automatic test_reset;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests_run++; if (mdu_output !== 64'h0) begin tests_failed++; $display("FAIL reset_output: got %h want 0", mdu_output); end
      rst = 1'b1;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_mul;
      int lat; logic [63:0] res;
      do_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL mul_neg: got %h want ffffffffffffffeb", res); end
      tests_run++; if (lat !== 67) begin tests_failed++; $display("FAIL mul_latency: got %0d want 67", lat); end
      do_op(OP_MUL, 64'h1234_5678_4000_0000, 64'h2, 1'b1, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_8000_0000) begin tests_failed++; $display("FAIL mulw_sext: got %h want ffffffff80000000", res); end
      tests_run++; if (lat !== 35) begin tests_failed++; $display("FAIL mulw_latency: got %0d want 35", lat); end
   endtask

   task automatic test_mulh;
      int lat; logic [63:0] res;
      do_op(OP_MULHU, '1, '1, 1'b0, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL mulhu: got %h want fffffffffffffffe", res); end
      do_op(OP_MULH, '1, '1, 1'b0, lat, res);
      tests_run++; if (res !== 64'h0) begin tests_failed++; $display("FAIL mulh: got %h want 0", res); end
      do_op(OP_MULHSU, '1, '1, 1'b0, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL mulhsu: got %h want ffffffffffffffff", res); end
      do_op(OP_MULHU, '1, '1, 1'b1, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE || lat !== 67) begin tests_failed++; $display("FAIL mulhu_word_ignored: got %h lat %0d want fffffffffffffffe lat 67", res, lat); end
   endtask

   task automatic test_div_zero;
      int lat; logic [63:0] res;
      do_op(OP_DIV, 64'd5, 64'd0, 1'b0, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL div_zero: got %h want ffffffffffffffff", res); end
      tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL div_zero_latency: got %0d want 2", lat); end
      do_op(OP_REMU, 64'd5, 64'd0, 1'b0, lat, res);
      tests_run++; if (res !== 64'd5 || lat !== 2) begin tests_failed++; $display("FAIL remu_zero: got %h lat %0d want 5 lat 2", res, lat); end
      do_op(OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 2) begin tests_failed++; $display("FAIL divw_ovf: got %h lat %0d want ffffffff80000000 lat 2", res, lat); end
   endtask

   task automatic test_overflow;
      int lat; logic [63:0] res;
      do_op(OP_DIV, 64'h8000_0000_0000_0000, '1, 1'b0, lat, res);
      tests_run++; if (res !== 64'h8000_0000_0000_0000 || lat !== 2) begin tests_failed++; $display("FAIL div_ovf: got %h lat %0d want 8000000000000000 lat 2", res, lat); end
      do_op(OP_REM, 64'h8000_0000_0000_0000, '1, 1'b0, lat, res);
      tests_run++; if (res !== 64'h0 || lat !== 2) begin tests_failed++; $display("FAIL rem_ovf: got %h lat %0d want 0 lat 2", res, lat); end
   endtask

   task automatic test_div;
      int lat; logic [63:0] res;
      do_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 35) begin tests_failed++; $display("FAIL divw: got %h lat %0d want fffffffffffffffd lat 35", res, lat); end
      do_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL remw: got %h want ffffffffffffffff", res); end
      do_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, lat, res);
      tests_run++; if (res !== 64'hFFFF_FFFF_FFFF_FFF2 || lat !== 67) begin tests_failed++; $display("FAIL div_neg: got %h lat %0d want fffffffffffffff2 lat 67", res, lat); end
      do_op(OP_DIVU, 64'd100, 64'd7, 1'b0, lat, res);
      tests_run++; if (res !== 64'd14) begin tests_failed++; $display("FAIL divu: got %h want e", res); end
      do_op(OP_REMU, 64'd100, 64'd7, 1'b0, lat, res);
      tests_run++; if (res !== 64'd2) begin tests_failed++; $display("FAIL remu: got %h want 2", res); end
   endtask

   task automatic test_back_to_back;
      int lat; logic [63:0] res;
      start_op(OP_DIV, 64'd5, 64'd0, 1'b0);
      wait_valid(lat);
      out_ready = 1'b1;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL handoff_in_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1 out_ready = 1'b0;
      tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL after_handoff: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
      do_op(OP_REMU, 64'd5, 64'd0, 1'b0, lat, res);
      tests_run++; if (res !== 64'd5 || lat !== 2) begin tests_failed++; $display("FAIL b2b_second: got %h lat %0d want 5 lat 2", res, lat); end
   endtask

   task automatic test_stall;
      int lat; int bad;
      start_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
      wait_valid(lat);
      bad = (lat < 0) ? 1 : 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || mdu_output !== 64'hFFFF_FFFF_FFFF_FFEB) bad++;
      end
      tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stall_hold: %0d bad cycles, last valid %b data %h want 1 ffffffffffffffeb", bad, out_valid, mdu_output); end
      handoff();
      tests_run++; if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL stall_release: valid %b busy %b want 0 0", out_valid, busy); end
   endtask

   task automatic test_flush;
      int seen;
      start_op(OP_DIVU, 64'd1000, 64'd3, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL flush_idle: in_ready %b busy %b want 1 0", in_ready, busy); end
      flush = 1'b1; in_valid = 1'b1; mdu_op = OP_DIVU; op1 = 64'd9; op2 = 64'd3; is_word_opt = 1'b0;
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL flush_no_result: %0d cycles with valid/busy, want 0", seen); end
   endtask

   task automatic test_reset_mid;
      int seen; int lat; logic [63:0] res;
      start_op(OP_DIVU, 64'd1000, 64'd3, 1'b0);
      repeat (20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset: busy %b valid %b want 0 0", busy, out_valid); end
      tests_run++; if (in_ready !== 1'b0 || mdu_output !== 64'h0) begin tests_failed++; $display("FAIL async_reset_out: in_ready %b data %h want 0 0", in_ready, mdu_output); end
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL reset_no_result: %0d valid cycles, want 0", seen); end
      do_op(OP_DIVU, 64'd100, 64'd7, 1'b0, lat, res);
      tests_run++; if (res !== 64'd14 || lat !== 67) begin tests_failed++; $display("FAIL post_reset_op: got %h lat %0d want e lat 67", res, lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div_zero();
      test_overflow();
      test_div();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
